// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction-fetch stage.
//   XLEN         - address / PC width
//   FETCH_PACKET - one decoded-stage slot: valid, pc, 32-bit instruction
//   FQ_ENTRY_W   - width of a stored queue entry (pc + inst, no valid bit)
package fetch_unit_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } FETCH_PACKET;

  localparam int FQ_ENTRY_W = XLEN + 32;

  // Pack a pc/instruction pair into a stored queue entry.
  function automatic logic [FQ_ENTRY_W-1:0] fq_entry(input logic [XLEN-1:0] pc,
                                                     input logic [31:0]     inst);
    return {pc, inst};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-in / 2-out circular instruction buffer.
//   clock, reset     - clock, async active-high reset
//   flush            - empties the queue; overrides enq/deq that cycle
//   enq_n            - entries written this cycle (0..2), enq0 first
//   enq0, enq1       - {pc, inst} entries to append
//   deq_n            - entries removed from the head this cycle (0..2)
//   head_pkts        - two oldest entries, slot 0 oldest; invalid slots read 0
//   count            - occupied entries (full/empty decided by count only)
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int FQ_DEPTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [1:0]                  enq_n,
  input  logic [FQ_ENTRY_W-1:0]       enq0,
  input  logic [FQ_ENTRY_W-1:0]       enq1,
  input  logic [1:0]                  deq_n,
  output FETCH_PACKET [1:0]           head_pkts,
  output logic [$clog2(FQ_DEPTH):0]   count
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  logic [FQ_ENTRY_W-1:0] r_mem [FQ_DEPTH];
  logic [PW-1:0]         r_head, r_tail;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         w_tail1, w_head1;

  // Pointers are exactly PW bits, so +1 wraps modulo the (power of two) depth.
  assign w_tail1 = r_tail + PW'(1);
  assign w_head1 = r_head + PW'(1);

  // Storage needs no reset: slots outside [head, head+count) are never shown.
  always_ff @(posedge clock) begin
    if (!flush) begin
      if (enq_n != 2'd0) r_mem[r_tail]  <= enq0;
      if (enq_n == 2'd2) r_mem[w_tail1] <= enq1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(deq_n);
      r_tail  <= r_tail + PW'(enq_n);
      r_count <= r_count + CW'(enq_n) - CW'(deq_n);
    end
  end

  always_comb begin
    head_pkts[0] = '0;
    head_pkts[1] = '0;
    if (r_count >= CW'(1)) head_pkts[0] = {1'b1, r_mem[r_head]};
    if (r_count >= CW'(2)) head_pkts[1] = {1'b1, r_mem[w_head1]};
  end

  assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, 64-bit line split and redirect handling in front
// of a fetch_queue feeding a 2-wide decode stage.
//   clock, reset       - clock, async active-high reset
//   Icache_data_out    - line data for the current lookup
//   Icache_valid_out   - line data valid (hit) this cycle
//   redirect_valid     - flush queue and restart at redirect_pc
//   redirect_pc        - restart PC (4-byte aligned)
//   deq_count          - instructions consumed by decode this cycle (0..2)
//   proc2Icache_addr   - current fetch PC
//   fetch_packet_out   - two oldest queued instructions, slot 0 oldest
//   fq_count           - occupied queue entries
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              FQ_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [63:0]               Icache_data_out,
  input  logic                      Icache_valid_out,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  input  logic [1:0]                deq_count,
  output logic [XLEN-1:0]           proc2Icache_addr,
  output FETCH_PACKET [1:0]         fetch_packet_out,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0]       r_pc;
  logic                  w_enq;
  logic                  w_upper;
  logic [1:0]            w_enq_n;
  logic [FQ_ENTRY_W-1:0] w_enq0, w_enq1;

  // Free space is judged before this cycle's dequeue and always demands room
  // for a full line, even when only the upper half will be written.
  assign w_enq   = Icache_valid_out && !redirect_valid &&
                   (fq_count <= CW'(FQ_DEPTH - 2));
  assign w_upper = r_pc[2];
  assign w_enq_n = !w_enq ? 2'd0 : (w_upper ? 2'd1 : 2'd2);

  // A PC in the upper half of the line takes only that half; the lower half
  // belongs to an earlier address.
  assign w_enq0 = w_upper ? fq_entry(r_pc, Icache_data_out[63:32])
                          : fq_entry(r_pc, Icache_data_out[31:0]);
  assign w_enq1 = fq_entry(r_pc + XLEN'(4), Icache_data_out[63:32]);

  // PC only moves on enqueue or redirect; the cache needs a stable address
  // for the whole duration of a miss or a full-queue stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= redirect_pc;
    else if (w_enq)          r_pc <= r_pc + (w_upper ? XLEN'(4) : XLEN'(8));
  end

  assign proc2Icache_addr = r_pc;

  fetch_queue #(.FQ_DEPTH(FQ_DEPTH)) u_fq (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .enq_n     (w_enq_n),
    .enq0      (w_enq0),
    .enq1      (w_enq1),
    .deq_n     (deq_count),
    .head_pkts (fetch_packet_out),
    .count     (fq_count)
  );

  // Decode may never take more than the valid head slots; during a redirect
  // deq_count is ignored, so it is not checked then.
  always @(posedge clock) begin
    if (!reset && !redirect_valid)
      assert (deq_count <= 2'd2 && CW'(deq_count) <= fq_count);
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          D   = 8;
  localparam logic [31:0] RPC = 32'h0;
  localparam logic [31:0] K   = 32'hC0DE_0000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [63:0]       Icache_data_out = '0;
  logic              Icache_valid_out = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic [1:0]        deq_count = '0;
  logic [31:0]       proc2Icache_addr;
  FETCH_PACKET [1:0] fetch_packet_out;
  logic [$clog2(D):0] fq_count;

  fetch_unit #(.FQ_DEPTH(D), .RESET_PC(RPC)) dut (
    .clock            (clock),
    .reset            (reset),
    .Icache_data_out  (Icache_data_out),
    .Icache_valid_out (Icache_valid_out),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .deq_count        (deq_count),
    .proc2Icache_addr (proc2Icache_addr),
    .fetch_packet_out (fetch_packet_out),
    .fq_count         (fq_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of fetched (pc, inst) pairs and a PC.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;

  typedef struct {
    logic hit; logic [63:0] d; logic rdr; logic [31:0] rp; logic [1:0] dq;
    logic [31:0] ea; int ec; FETCH_PACKET e0; FETCH_PACKET e1;
  } vec_t;
  vec_t tv[14];

  function automatic logic [63:0] ln(input logic [31:0] a);
    return {(a + 32'd4) ^ K, a ^ K};
  endfunction

  function automatic FETCH_PACKET pk(input logic [31:0] a);
    return {1'b1, a, a ^ K};
  endfunction

  function automatic vec_t V(input logic hit, input logic [63:0] d, input logic rdr,
                             input logic [31:0] rp, input logic [1:0] dq,
                             input logic [31:0] ea, input int ec,
                             input FETCH_PACKET e0, input FETCH_PACKET e1);
    vec_t v;
    v.hit = hit; v.d = d; v.rdr = rdr; v.rp = rp; v.dq = dq;
    v.ea = ea; v.ec = ec; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  function automatic FETCH_PACKET exp_pkt(input int i);
    if (mq.size() > i) return {1'b1, mq[i].pc, mq[i].inst};
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = RPC;
  endtask

  // Drive one cycle's inputs, advance the model at the edge, settle #1.
  task automatic cyc(input logic hit, input logic [63:0] d, input logic rdr,
                     input logic [31:0] rp, input logic [1:0] dq);
    int n0;
    Icache_valid_out = hit; Icache_data_out = d;
    redirect_valid = rdr; redirect_pc = rp; deq_count = dq;
    @(posedge clock);
    n0 = mq.size();
    if (rdr) begin
      mq.delete();
      mpc = rp;
    end else begin
      for (int i = 0; i < int'(dq); i++) void'(mq.pop_front());
      if (hit && (D - n0) >= 2) begin
        if (!mpc[2]) begin
          mq.push_back('{mpc, d[31:0]});
          mq.push_back('{mpc + 32'd4, d[63:32]});
          mpc = mpc + 32'd8;
        end else begin
          mq.push_back('{mpc, d[63:32]});
          mpc = mpc + 32'd4;
        end
      end
    end
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, " addr"},  96'(proc2Icache_addr),    96'(mpc));
    chk({nm, " count"}, 96'(fq_count),            96'(mq.size()));
    chk({nm, " pkt0"},  96'(fetch_packet_out[0]), 96'(exp_pkt(0)));
    chk({nm, " pkt1"},  96'(fetch_packet_out[1]), 96'(exp_pkt(1)));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " addr"},  96'(proc2Icache_addr),    96'(RPC));
    chk({nm, " count"}, 96'(fq_count),            96'(0));
    chk({nm, " pkt0"},  96'(fetch_packet_out[0]), 96'(0));
    chk({nm, " pkt1"},  96'(fetch_packet_out[1]), 96'(0));
  endtask

  initial begin
    // Directed table: aligned streaming, stalls, 5-cycle miss, redirect to an
    // upper-half PC.
    tv[0]  = V(1, ln(32'h0),  0, 0, 0, 32'h8,  2, pk(32'h0),  pk(32'h4));
    tv[1]  = V(1, ln(32'h8),  0, 0, 2, 32'h10, 2, pk(32'h8),  pk(32'hC));
    tv[2]  = V(1, ln(32'h10), 0, 0, 2, 32'h18, 2, pk(32'h10), pk(32'h14));
    tv[3]  = V(0, 64'hDEAD,   0, 0, 0, 32'h18, 2, pk(32'h10), pk(32'h14));
    tv[4]  = V(0, 64'hDEAD,   0, 0, 1, 32'h18, 1, pk(32'h14), '0);
    tv[5]  = V(1, ln(32'h18), 0, 0, 1, 32'h20, 2, pk(32'h18), pk(32'h1C));
    for (int i = 6; i <= 10; i++)
      tv[i] = V(0, 64'hDEAD, 0, 0, 0, 32'h20, 2, pk(32'h18), pk(32'h1C));
    tv[11] = V(1, ln(32'h20), 0, 0, 0, 32'h28, 4, pk(32'h18), pk(32'h1C));
    tv[12] = V(1, ln(32'h28), 1, 32'h104, 2, 32'h104, 0, '0, '0);
    tv[13] = V(1, 64'hBBBBBBBB_AAAAAAAA, 0, 0, 0, 32'h108, 1,
               {1'b1, 32'h104, 32'hBBBBBBBB}, '0);

    model_reset();
    #12;
    chk_reset_vals("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      cyc(tv[i].hit, tv[i].d, tv[i].rdr, tv[i].rp, tv[i].dq);
      chk({nm, " addr"},  96'(proc2Icache_addr),    96'(tv[i].ea));
      chk({nm, " count"}, 96'(fq_count),            96'(tv[i].ec));
      chk({nm, " pkt0"},  96'(fetch_packet_out[0]), 96'(tv[i].e0));
      chk({nm, " pkt1"},  96'(fetch_packet_out[1]), 96'(tv[i].e1));
    end

    // Asynchronous reset pulse entirely between two posedges.
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    #1 reset = 1'b0;
    model_reset();

    // Fill with no dequeue: 2,4,6,8 then hold with PC frozen.
    for (int k = 1; k <= 6; k++) begin
      int ec;
      ec = (k <= 4) ? 2 * k : 8;
      cyc(1, ln(mpc), 0, 0, 0);
      chk($sformatf("fill%0d count", k), 96'(fq_count), 96'(ec));
      chk($sformatf("fill%0d addr", k),  96'(proc2Icache_addr), 96'(32'(ec * 4)));
    end

    // Drain 2/cycle on misses: head pc advances in order through the wrap.
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 64'h0, 0, 0, 2);
      chk($sformatf("drain%0d count", k), 96'(fq_count), 96'(8 - 2 * k));
      chk($sformatf("drain%0d head", k),  96'(fetch_packet_out[0].pc), 96'(32'(8 * k)));
    end

    // Streaming with dequeue after pointers have wrapped.
    for (int k = 0; k < 10; k++) begin
      int n;
      n = (mq.size() < 2) ? mq.size() : 2;
      cyc(1, ln(mpc), 0, 0, 2'(n));
      chk_model($sformatf("wrap%0d", k));
    end

    // Redirect while 6 entries are queued and decode also dequeues.
    cyc(0, 64'h0, 1, 32'h300, 0);
    for (int k = 0; k < 3; k++) cyc(1, ln(mpc), 0, 0, 0);
    chk("pre_rdr count", 96'(fq_count), 96'(6));
    cyc(1, ln(mpc), 1, 32'h400, 2);
    chk("rdr count", 96'(fq_count), 96'(0));
    chk("rdr addr",  96'(proc2Icache_addr), 96'(32'h400));
    chk("rdr pkt0",  96'(fetch_packet_out[0]), 96'(0));
    chk("rdr pkt1",  96'(fetch_packet_out[1]), 96'(0));
    cyc(1, ln(32'h400), 0, 0, 0);
    chk("rdr_next pkt0", 96'(fetch_packet_out[0]), 96'(pk(32'h400)));
    chk("rdr_next addr", 96'(proc2Icache_addr), 96'(32'h408));

    // Randomized traffic against the model, including PC wrap at 2^32.
    for (int k = 0; k < 400; k++) begin
      logic        hit, rdr;
      logic [31:0] rp;
      int          mx;
      hit = ($urandom % 4) != 0;
      rdr = ($urandom % 16) == 0;
      rp  = (($urandom % 3) == 0) ? (32'hFFFF_FFF0 + 32'(($urandom % 4) * 4))
                                  : ($urandom & 32'hFFFF_FFFC);
      mx  = (mq.size() < 2) ? mq.size() : 2;
      cyc(hit, {$urandom, $urandom}, rdr, rp, 2'($urandom_range(mx, 0)));
      chk_model($sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
